jtag_shift_engine: RTL and testbench
====================================

# jtag_shift_engine

Synthesizable JTAG command engine that replaces the simulation-only DPI driver in hardware builds. It accepts JTAG commands (TAP reset, TMS sequence, scan, scan with TMS flip on the last bit) over a valid/ready command port and fetches TDI/TMS bytes from a byte stream. It generates TCK/TMS/TDI from the system clock and returns captured TDO bytes on a second byte stream. It sits between the debug transport (UART/TCP bridge FIFOs) and the target TAP.

## Interface
- TCK_HALF_PERIOD, 4: clk cycles per TCK half period; legal range ≥ 1.
- NB_BITS_W, 16: width of the bit-count field.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine can accept a command (high only in IDLE).
- cmd_op  in  3  0=RESET, 1=TMS_SEQ, 2=SCAN, 3=SCAN_FLIP_TMS; 4..7 illegal.
- cmd_nb_bits  in  NB_BITS_W  number of bits to shift; ignored for RESET.
- out_valid / out_ready / out_data[7:0]  in/out/in  outbound byte stream (TMS bits for TMS_SEQ, TDI bits for scans), LSB shifted first.
- in_valid / in_ready / in_data[7:0]  out/in/out  captured TDO bytes (scans only).
- cmd_done  out  1  one-cycle pulse when a command completes.
- cmd_err  out  1  one-cycle pulse when an illegal op is dropped.
- tck, tms, tdi  out  1  JTAG outputs. tdo  in  1  JTAG input; already synchronous to clk.

## Operation
- Command and byte transfers occur on a clk edge where valid and ready are both high.
- Reset values: tck=0, tms=0, tdi=0, cmd_ready=1, out_ready=0, in_valid=0, in_data=0, cmd_done=0, cmd_err=0; FSM in IDLE.
- FSM states:
  - IDLE: cmd_ready=1.
  - FETCH: out_ready=1; wait for a byte.
  - LOW: tck=0, TCK_HALF_PERIOD cycles.
  - HIGH: tck=1, TCK_HALF_PERIOD cycles.
  - PUSH: in_valid=1; wait for in_ready.
  - DONE: cmd_done pulse, then IDLE.
- RESET op: shift internal pattern 6'b011111, LSB first, on TMS (5 ones then one zero → Run-Test/Idle). TDI=0. No byte traffic.
- TMS_SEQ: bits go on TMS, TDI=0. No TDO capture and no in_* traffic.
- SCAN: bits go on TDI, TMS=0. TDO is captured per bit.
- SCAN_FLIP_TMS: same as SCAN, but TMS=1 for the final bit only.
- Bytes consumed per command = ceil(nb_bits/8). The last byte uses only its low (nb_bits mod 8, or 8 if 0) bits; its upper bits are ignored.
- TDO bit k of a byte is written to captured bit k. Unused upper bits of the last captured byte are 0.
- Each captured byte is pushed in PUSH after its last bit's TCK falling edge. The next byte is not fetched until in_data is accepted; tck stays 0 while stalled.
- nb_bits=0 on TMS_SEQ or SCAN*: no byte traffic, no TCK; go directly to DONE.
- Illegal op: accepted, cmd_err pulses, cmd_done does not pulse, return to IDLE; no pin activity.
- After the final bit, tms and tdi return to 0 on the final tck falling edge.
- The bit counter counts down nb_bits, or 6 for RESET. The byte boundary is reached when the in-byte bit index wraps 7→0.

## Timing
- Command accepted at edge E0 → FSM in FETCH (or LOW for RESET) from E0.
- RESET op: bit 0 tms/tdi are driven at E0+1.
- Data ops: bit 0 tms/tdi are registered on the edge the byte is accepted (Ef).
- tck rises TCK_HALF_PERIOD edges after the bit's tms/tdi update. tdo is sampled on that same edge.
- tck falls TCK_HALF_PERIOD edges later. The next bit's tms/tdi update on that same edge, so TMS/TDI change only while tck is falling or low.
- Within a byte: one TCK period = 2*TCK_HALF_PERIOD clk cycles, no gaps between bits.
- cmd_done pulses on the edge after the last falling tck edge, or after the last PUSH handshake for scans. cmd_ready returns high on the following edge.
- rst mid-command: all outputs go to reset values immediately. Partial bytes and pending in_data are discarded.

## Test plan
- TCK_HALF_PERIOD=2; RESET op → 6 TCK pulses of 4 clk each; TMS=1,1,1,1,1,0 at the rising edges; cmd_done 1 cycle after the last fall.
- TMS_SEQ nb_bits=3, byte 0x05 → TMS=1,0,1 at the rising edges; TDI stays 0; no in_valid; 3 TCK pulses.
- SCAN nb_bits=8, byte 0xA5, tdo looped to tdi → in_data=0xA5, exactly one in_valid handshake, TMS=0 throughout.
- SCAN_FLIP_TMS nb_bits=10, bytes 0xFF,0x02, tdo tied 1 → TMS=1 only on bit 9; captured 0xFF then 0x03.
- Stall checks:
  - out_valid held low 7 cycles mid-scan → tck held 0, no extra pulses.
  - in_ready low 5 cycles → next byte not fetched until accepted.
- Errors and reset:
  - cmd_op=5 → cmd_err pulse, no pin toggles.
  - nb_bits=0 SCAN → cmd_done, no bytes.
  - rst asserted in HIGH state → tck/tms/tdi=0 and cmd_ready=1 immediately.

Source files
------------

// File: rtl/jtag_shift_engine_if.sv
// Command port plus outbound/inbound byte streams of the JTAG shift
// engine; the transport side is master, the engine is slave.
interface jtag_shift_engine_if #(
   parameter int NB_BITS_W = 16
);
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [2:0]           cmd_op;
   logic [NB_BITS_W-1:0] cmd_nb_bits;
   logic                 cmd_done;
   logic                 cmd_err;
   logic                 out_valid;
   logic                 out_ready;
   logic [7:0]           out_data;
   logic                 in_valid;
   logic                 in_ready;
   logic [7:0]           in_data;

   modport master (
      output cmd_valid, cmd_op, cmd_nb_bits,
      input  cmd_ready, cmd_done, cmd_err,
      output out_valid, out_data,
      input  out_ready,
      input  in_valid, in_data,
      output in_ready
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_nb_bits,
      output cmd_ready, cmd_done, cmd_err,
      input  out_valid, out_data,
      output out_ready,
      output in_valid, in_data,
      input  in_ready
   );
endinterface

// File: rtl/jtag_shift_engine.sv
// JTAG command engine: turns TAP commands and TDI/TMS byte streams
// into TCK/TMS/TDI waveforms and returns captured TDO bytes.
module jtag_shift_engine #(
   parameter int TCK_HALF_PERIOD = 4,
   parameter int NB_BITS_W       = 16
) (
   input  logic               clk,
   input  logic               rst,
   jtag_shift_engine_if.slave bus,
   output logic               tck,
   output logic               tms,
   output logic               tdi,
   input  logic               tdo
);

   localparam int TW =
      (TCK_HALF_PERIOD > 1) ? $clog2(TCK_HALF_PERIOD) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(TCK_HALF_PERIOD - 1);
   localparam logic [NB_BITS_W-1:0] ONE = NB_BITS_W'(1);
   localparam logic [NB_BITS_W-1:0] TWO = NB_BITS_W'(2);
   localparam logic [1:0] OP_RESET = 2'd0;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_LOW, S_HIGH, S_PUSH, S_DONE
   } state_e;

   state_e               state_q, state_d;
   logic [TW-1:0]        tmr_q, tmr_d;
   logic [NB_BITS_W-1:0] left_q, left_d;
   logic [2:0]           idx_q, idx_d;
   logic [2:0]           idx_nx;
   logic [7:0]           byte_q, byte_d;
   logic [7:0]           cap_q, cap_d;
   logic [1:0]           op_q, op_d;
   logic                 pend_q, pend_d;
   logic                 tck_q, tck_d;
   logic                 tms_q, tms_d;
   logic                 tdi_q, tdi_d;
   logic                 cmd_ready_q, cmd_ready_d;
   logic                 out_ready_q, out_ready_d;
   logic                 in_valid_q, in_valid_d;
   logic [7:0]           in_data_q, in_data_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;

   // Returns {tms, tdi}: scans put data on TDI, the rest on TMS.
   function automatic logic [1:0] pins(
      input logic [1:0] op,
      input logic       b,
      input logic       last
   );
      return op[1] ? {op[0] & last, b} : {b, 1'b0};
   endfunction

   assign idx_nx = idx_q + 3'd1;

   always_comb begin
      state_d   = state_q;
      tmr_d     = tmr_q;
      left_d    = left_q;
      idx_d     = idx_q;
      byte_d    = byte_q;
      cap_d     = cap_q;
      op_d      = op_q;
      pend_d    = pend_q;
      tck_d     = tck_q;
      tms_d     = tms_q;
      tdi_d     = tdi_q;
      in_data_d = in_data_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid && cmd_ready_q) begin
               op_d  = bus.cmd_op[1:0];
               idx_d = '0;
               tmr_d = '0;
               cap_d = '0;
               if (bus.cmd_op[2]) begin
                  err_d = 1'b1;
               end else if (bus.cmd_op[1:0] == OP_RESET) begin
                  // Five ones then a zero walks any TAP to Run-Test/Idle.
                  byte_d  = 8'h1f;
                  left_d  = NB_BITS_W'(6);
                  pend_d  = 1'b1;
                  state_d = S_LOW;
               end else if (bus.cmd_nb_bits == '0) begin
                  state_d = S_DONE;
               end else begin
                  left_d  = bus.cmd_nb_bits;
                  state_d = S_FETCH;
               end
            end
         end
         S_FETCH: begin
            if (bus.out_valid && out_ready_q) begin
               byte_d  = bus.out_data;
               cap_d   = '0;
               idx_d   = '0;
               tmr_d   = '0;
               {tms_d, tdi_d} =
                  pins(op_q, bus.out_data[0], left_q == ONE);
               state_d = S_LOW;
            end
         end
         S_LOW: begin
            if (pend_q) begin
               pend_d = 1'b0;
               {tms_d, tdi_d} = pins(op_q, byte_q[0], 1'b0);
            end else if (tmr_q == T_LAST) begin
               tmr_d        = '0;
               tck_d        = 1'b1;
               cap_d[idx_q] = tdo;
               state_d      = S_HIGH;
            end else begin
               tmr_d = tmr_q + TW'(1);
            end
         end
         S_HIGH: begin
            if (tmr_q == T_LAST) begin
               tmr_d  = '0;
               tck_d  = 1'b0;
               left_d = left_q - ONE;
               idx_d  = idx_nx;
               if (left_q == ONE) begin
                  tms_d = 1'b0;
                  tdi_d = 1'b0;
                  if (op_q[1]) begin
                     in_data_d = cap_q;
                     state_d   = S_PUSH;
                  end else begin
                     state_d = S_DONE;
                  end
               end else if (idx_q == 3'd7) begin
                  if (op_q[1]) begin
                     in_data_d = cap_q;
                     state_d   = S_PUSH;
                  end else begin
                     state_d = S_FETCH;
                  end
               end else begin
                  {tms_d, tdi_d} =
                     pins(op_q, byte_q[idx_nx], left_q == TWO);
                  state_d = S_LOW;
               end
            end else begin
               tmr_d = tmr_q + TW'(1);
            end
         end
         S_PUSH: begin
            if (in_valid_q && bus.in_ready) begin
               state_d = (left_q == '0) ? S_DONE : S_FETCH;
            end
         end
         S_DONE: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // Ready lags entry to IDLE by one edge so it follows cmd_done.
      cmd_ready_d = (state_d == S_IDLE) && (state_q == S_IDLE);
      out_ready_d = (state_d == S_FETCH);
      in_valid_d  = (state_d == S_PUSH);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         tmr_q       <= '0;
         left_q      <= '0;
         idx_q       <= '0;
         byte_q      <= '0;
         cap_q       <= '0;
         op_q        <= '0;
         pend_q      <= 1'b0;
         tck_q       <= 1'b0;
         tms_q       <= 1'b0;
         tdi_q       <= 1'b0;
         cmd_ready_q <= 1'b1;
         out_ready_q <= 1'b0;
         in_valid_q  <= 1'b0;
         in_data_q   <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         tmr_q       <= tmr_d;
         left_q      <= left_d;
         idx_q       <= idx_d;
         byte_q      <= byte_d;
         cap_q       <= cap_d;
         op_q        <= op_d;
         pend_q      <= pend_d;
         tck_q       <= tck_d;
         tms_q       <= tms_d;
         tdi_q       <= tdi_d;
         cmd_ready_q <= cmd_ready_d;
         out_ready_q <= out_ready_d;
         in_valid_q  <= in_valid_d;
         in_data_q   <= in_data_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign tck           = tck_q;
   assign tms           = tms_q;
   assign tdi           = tdi_q;
   assign bus.cmd_ready = cmd_ready_q;
   assign bus.out_ready = out_ready_q;
   assign bus.in_valid  = in_valid_q;
   assign bus.in_data   = in_data_q;
   assign bus.cmd_done  = done_q;
   assign bus.cmd_err   = err_q;

endmodule

// File: tb/tb_jtag_shift_engine.sv
// Bench for jtag_shift_engine: directed and random commands checked
// against a bit-level model of the TMS/TDI sequence and TDO capture.
module tb_jtag_shift_engine;
   localparam int H   = 2;
   localparam int NBW = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tck, tms, tdi, tdo;
   int   tmode = 0;

   jtag_shift_engine_if #(.NB_BITS_W(NBW)) bus ();

   jtag_shift_engine #(
      .TCK_HALF_PERIOD(H),
      .NB_BITS_W(NBW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus),
      .tck(tck),
      .tms(tms),
      .tdi(tdi),
      .tdo(tdo)
   );

   always #5 clk = ~clk;

   assign tdo = (tmode == 0) ? tdi : (tmode == 1) ? 1'b1 : ~tdi;

   typedef struct {
      logic [7:0] b;
      int         gap;
   } tx_t;

   tx_t        txq[$];
   logic [7:0] cmd_bytes[$];
   logic [1:0] got_bits[$];
   logic [1:0] exp_bits[$];
   logic [7:0] got_cap[$];
   logic [7:0] exp_cap[$];

   int total = 0;
   int bad   = 0;
   int cyc = 0, n_out = 0, n_done = 0, n_err = 0;
   int hi_cnt = 0, hi_bad = 0, pin_bad = 0, ord_bad = 0, act = 0;
   int done_s = 0, evt_s = 0;
   int in_gap = 0, in_wait = 0;
   logic       tck_p = 1'b0;
   logic [1:0] pins_p = 2'b00;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Posedge monitor sees the values held during the cycle just ended.
   initial forever begin
      @(posedge clk);
      cyc++;
      if (!rst) begin
         if (tck && !tck_p) got_bits.push_back({tms, tdi});
         if (tck && tck_p && ({tms, tdi} != pins_p)) pin_bad++;
         if (tck) hi_cnt++;
         if (!tck && tck_p) begin
            if (hi_cnt != H) hi_bad++;
            hi_cnt = 0;
            evt_s  = cyc;
         end
         if (tck && (bus.out_ready || bus.in_valid)) ord_bad++;
         if (bus.out_valid && bus.out_ready) begin
            n_out++;
            if (bus.in_valid) ord_bad++;
            if (txq.size() > 0) void'(txq.pop_front());
         end
         if (bus.in_valid && bus.in_ready) begin
            got_cap.push_back(bus.in_data);
            evt_s = cyc + 1;
         end
         if (bus.cmd_done) begin
            n_done++;
            done_s = cyc;
         end
         if (bus.cmd_err) n_err++;
         if (tck || tms || tdi) act++;
      end
      tck_p  = tck;
      pins_p = {tms, tdi};
   end

   initial begin
      bus.out_valid = 1'b0;
      bus.out_data  = 8'h00;
      forever begin
         @(negedge clk);
         if (txq.size() > 0 && txq[0].gap > 0) begin
            bus.out_valid = 1'b0;
            txq[0].gap    = txq[0].gap - 1;
         end else if (txq.size() > 0) begin
            bus.out_valid = 1'b1;
            bus.out_data  = txq[0].b;
         end else begin
            bus.out_valid = 1'b0;
         end
      end
   end

   initial begin
      bus.in_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.in_valid) begin
            bus.in_ready = (in_wait >= in_gap);
            in_wait++;
         end else begin
            bus.in_ready = 1'b0;
            in_wait      = 0;
         end
      end
   end

   task automatic run_cmd(input int op, input int nb, input int tm,
                          input int ig, input int stall_at,
                          input int stall_len);
      int         nbytes, n, tmo;
      logic       legal, bb, cb;
      logic [7:0] t;
      tx_t        e;
      tmode  = tm;
      in_gap = ig;
      exp_bits.delete();
      exp_cap.delete();
      got_bits.delete();
      got_cap.delete();
      n_out = 0; n_done = 0; n_err = 0;
      hi_bad = 0; pin_bad = 0; ord_bad = 0; act = 0;
      evt_s = 0; done_s = 0;
      legal  = (op < 4);
      nbytes = (legal && op != 0) ? (nb + 7) / 8 : 0;
      while (cmd_bytes.size() < nbytes)
         cmd_bytes.push_back(8'($urandom));
      for (int j = 0; j < nbytes; j++) begin
         e.b   = cmd_bytes[j];
         e.gap = (j == stall_at) ? stall_len : 0;
         txq.push_back(e);
      end
      n = !legal ? 0 : (op == 0) ? 6 : nb;
      for (int i = 0; i < n; i++) begin
         bb = (op == 0) ? (i < 5) : cmd_bytes[i / 8][i % 8];
         case (op)
            0, 1:    exp_bits.push_back({bb, 1'b0});
            2:       exp_bits.push_back({1'b0, bb});
            default: exp_bits.push_back({(i == n - 1), bb});
         endcase
         if (op >= 2) begin
            if (i % 8 == 0) exp_cap.push_back(8'h00);
            cb = (tm == 0) ? bb : (tm == 1) ? 1'b1 : ~bb;
            t = exp_cap[i / 8];
            t[i % 8] = cb;
            exp_cap[i / 8] = t;
         end
      end

      @(negedge clk);
      bus.cmd_valid   = 1'b1;
      bus.cmd_op      = 3'(op);
      bus.cmd_nb_bits = NBW'(nb);
      tmo = 0;
      while (!bus.cmd_ready && tmo < 100) begin
         @(negedge clk);
         tmo++;
      end
      chk("cmd_accept", 32'(bus.cmd_ready), 1);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      tmo = 0;
      while (n_done == 0 && n_err == 0 && tmo < 4000) begin
         @(negedge clk);
         tmo++;
      end
      chk("cmd_finish", 32'(n_done + n_err > 0), 1);
      repeat (3) @(negedge clk);

      chk("done_count", 32'(n_done), legal ? 1 : 0);
      chk("err_count", 32'(n_err), legal ? 0 : 1);
      chk("tck_pulses", 32'(got_bits.size()), 32'(exp_bits.size()));
      for (int i = 0; i < exp_bits.size() && i < got_bits.size(); i++)
         chk($sformatf("bit%0d_tms_tdi", i),
             32'(got_bits[i]), 32'(exp_bits[i]));
      chk("in_bytes", 32'(got_cap.size()), 32'(exp_cap.size()));
      for (int i = 0; i < exp_cap.size() && i < got_cap.size(); i++)
         chk($sformatf("in_data%0d", i),
             32'(got_cap[i]), 32'(exp_cap[i]));
      chk("out_bytes", 32'(n_out), 32'(nbytes));
      chk("tck_high_width", 32'(hi_bad), 0);
      chk("pins_stable_high", 32'(pin_bad), 0);
      chk("stall_order", 32'(ord_bad), 0);
      chk("idle_pins", 32'({tck, tms, tdi}), 0);
      chk("ready_after", 32'(bus.cmd_ready), 1);
      chk("txq_drained", 32'(txq.size()), 0);
      if (exp_bits.size() > 0)
         chk("done_latency", 32'(done_s - evt_s), 1);
      if (!legal)
         chk("err_no_pins", 32'(act), 0);
      cmd_bytes.delete();
   endtask

   initial begin
      int  tmo;
      tx_t e;
      bus.cmd_valid   = 1'b0;
      bus.cmd_op      = 3'd0;
      bus.cmd_nb_bits = '0;
      repeat (3) @(negedge clk);
      chk("rst_tck", 32'(tck), 0);
      chk("rst_tms", 32'(tms), 0);
      chk("rst_tdi", 32'(tdi), 0);
      chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
      chk("rst_out_ready", 32'(bus.out_ready), 0);
      chk("rst_in_valid", 32'(bus.in_valid), 0);
      chk("rst_in_data", 32'(bus.in_data), 0);
      chk("rst_cmd_done", 32'(bus.cmd_done), 0);
      chk("rst_cmd_err", 32'(bus.cmd_err), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      run_cmd(0, 0, 0, 0, -1, 0);
      cmd_bytes = '{8'h05};
      run_cmd(1, 3, 0, 0, -1, 0);
      cmd_bytes = '{8'hA5};
      run_cmd(2, 8, 0, 0, -1, 0);
      cmd_bytes = '{8'hFF, 8'h02};
      run_cmd(3, 10, 1, 0, -1, 0);
      run_cmd(2, 24, 2, 0, 1, 7);
      run_cmd(3, 16, 0, 5, -1, 0);
      run_cmd(3, 1, 0, 0, -1, 0);
      run_cmd(1, 12, 0, 0, 1, 3);
      run_cmd(5, 12, 0, 0, -1, 0);
      run_cmd(2, 0, 0, 0, -1, 0);
      run_cmd(1, 0, 0, 0, -1, 0);
      for (int k = 0; k < 8; k++)
         run_cmd(int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 40)),
                 int'($urandom_range(0, 2)),
                 int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 5)),
                 int'($urandom_range(0, 4)));

      tmode  = 0;
      in_gap = 0;
      e.b    = 8'hFF;
      e.gap  = 0;
      txq.push_back(e);
      txq.push_back(e);
      @(negedge clk);
      bus.cmd_valid   = 1'b1;
      bus.cmd_op      = 3'd2;
      bus.cmd_nb_bits = NBW'(16);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      tmo = 0;
      while (!tck && tmo < 200) begin
         @(negedge clk);
         tmo++;
      end
      chk("mid_reached_high", 32'(tck), 1);
      chk("mid_tdi_before", 32'(tdi), 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_tck", 32'(tck), 0);
      chk("mid_rst_tms", 32'(tms), 0);
      chk("mid_rst_tdi", 32'(tdi), 0);
      chk("mid_rst_cmd_ready", 32'(bus.cmd_ready), 1);
      chk("mid_rst_out_ready", 32'(bus.out_ready), 0);
      chk("mid_rst_in_valid", 32'(bus.in_valid), 0);
      repeat (2) @(negedge clk);
      txq.delete();
      hi_cnt = 0;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      cmd_bytes = '{8'h3C};
      run_cmd(2, 8, 0, 0, -1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
